// File: rtl/param_counter_pkg.sv
// Shared constants for the parameterised up/down counter.
// Holds the SATURATE mode encodings, the legal WIDTH range and the internal
// step encoding used by the next-value logic.
package param_counter_pkg;

  // SATURATE parameter encodings
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Legal WIDTH range
  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  // Action selected for the current edge, after Load/Enable priority
  typedef enum logic [1:0] {
    StepHold,
    StepLoad,
    StepUp,
    StepDown
  } step_e;

endpackage

// File: rtl/param_counter_count_next.sv
// Combinational next-value and limit-compare logic for param_counter.
// Ports:
//   count_i     current registered count
//   enable_i    count step enable
//   up_down_i   1 = up, 0 = down
//   load_i      parallel load strobe (wins over enable_i)
//   load_val_i  value to load, clamped to Max
//   count_o     next count value (before reset is applied)
//   tc_o        next terminal-count flag: set when a step hits a limit
//   at_limit_o  current count sits at the limit of the selected direction
module count_next
  import param_counter_pkg::*;
#(
  parameter int unsigned Width    = 4,
  parameter int unsigned Max      = 15,
  parameter int unsigned Saturate = MODE_WRAP
) (
  input  logic [Width-1:0] count_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o,
  output logic             at_limit_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);
  localparam logic [Width-1:0] One    = Width'(1);
  localparam bit               SatMode = (Saturate == MODE_SAT);

  step_e step;

  always_comb begin
    step = StepHold;
    if (load_i) begin
      step = StepLoad;
    end else if (enable_i) begin
      step = up_down_i ? StepUp : StepDown;
    end
  end

  always_comb begin
    count_o = count_i;
    tc_o    = 1'b0;
    unique case (step)
      StepLoad: begin
        count_o = (load_val_i > MaxVal) ? MaxVal : load_val_i;
      end
      StepUp: begin
        // >= keeps the counter bounded even if count_i were ever above MaxVal
        if (count_i >= MaxVal) begin
          tc_o    = 1'b1;
          count_o = SatMode ? MaxVal : '0;
        end else begin
          count_o = count_i + One;
        end
      end
      StepDown: begin
        if (count_i == '0) begin
          tc_o    = 1'b1;
          count_o = SatMode ? '0 : MaxVal;
        end else begin
          count_o = count_i - One;
        end
      end
      default: begin
        count_o = count_i;
        tc_o    = 1'b0;
      end
    endcase
  end

  assign at_limit_o = up_down_i ? (count_i == MaxVal) : (count_i == '0);

endmodule

// File: rtl/param_counter.sv
// Parameterised up/down counter with load, wrap or saturate at limits, and a
// registered terminal-count pulse.
// Ports:
//   Clk      rising-edge clock
//   Rst      synchronous active-high reset (highest priority)
//   Enable   count step enable
//   UpDown   1 = count up, 0 = count down
//   Load     synchronous parallel load strobe (beats Enable)
//   LoadVal  value to load, clamped to MAX
//   Count    registered count value
//   Tc       registered one-cycle pulse after a step at a limit
//   AtLimit  combinational: Count at the limit of the UpDown direction
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             UpDown,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             AtLimit
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("param_counter: WIDTH out of range");
  end
  if (MAX < 1 || MAX > 2**WIDTH - 1) begin : g_bad_max
    $error("param_counter: MAX out of range");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("param_counter: SATURATE must be MODE_WRAP or MODE_SAT");
  end

  logic [WIDTH-1:0] count_d, count_q;
  logic             tc_d, tc_q;

  count_next #(
    .Width    (WIDTH),
    .Max      (MAX),
    .Saturate (SATURATE)
  ) u_count_next (
    .count_i    (count_q),
    .enable_i   (Enable),
    .up_down_i  (UpDown),
    .load_i     (Load),
    .load_val_i (LoadVal),
    .count_o    (count_d),
    .tc_o       (tc_d),
    .at_limit_o (AtLimit)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign Count = count_q;
  assign Tc    = tc_q;

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter. Three instances share the stimulus:
// wrap (MAX=9), saturate (MAX=9) and default parameters (WIDTH=4, MAX=15).
module tb_param_counter;

  logic       Clk;
  logic       Rst;
  logic       Enable;
  logic       UpDown;
  logic       Load;
  logic [3:0] LoadVal;

  logic [3:0] cnt_w, cnt_s, cnt_d;
  logic       tc_w, tc_s, tc_d;
  logic       al_w, al_s, al_d;

  int n_checks = 0;
  int n_errors = 0;

  param_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_wrap (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .UpDown(UpDown), .Load(Load),
    .LoadVal(LoadVal), .Count(cnt_w), .Tc(tc_w), .AtLimit(al_w)
  );

  param_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_sat (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .UpDown(UpDown), .Load(Load),
    .LoadVal(LoadVal), .Count(cnt_s), .Tc(tc_s), .AtLimit(al_s)
  );

  param_counter u_def (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .UpDown(UpDown), .Load(Load),
    .LoadVal(LoadVal), .Count(cnt_d), .Tc(tc_d), .AtLimit(al_d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [3:0] cw; logic tw;
    logic [3:0] cs; logic ts;
    logic [3:0] cd; logic td;
  } exp_t;

  exp_t sb_q[$];

  int         m_max [3] = '{9, 9, 15};
  bit         m_sat [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] m_cnt [3];
  bit         m_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference behaviour of one counter for one edge
  function automatic void model_step(input logic [3:0] cnt, input int mx, input bit sat,
                                     input bit rst, input bit ld, input logic [3:0] lv,
                                     input bit en, input bit ud,
                                     output logic [3:0] nc, output logic ntc);
    nc  = cnt;
    ntc = 1'b0;
    if (rst) begin
      nc = 4'd0;
    end else if (ld) begin
      nc = (int'(lv) > mx) ? 4'(mx) : lv;
    end else if (en && ud) begin
      if (int'(cnt) == mx) begin
        ntc = 1'b1;
        nc  = sat ? 4'(mx) : 4'd0;
      end else begin
        nc = cnt + 4'd1;
      end
    end else if (en) begin
      if (cnt == 4'd0) begin
        ntc = 1'b1;
        nc  = sat ? 4'd0 : 4'(mx);
      end else begin
        nc = cnt - 4'd1;
      end
    end
  endfunction

  function automatic logic exp_atlim(input int i, input bit ud);
    return ud ? (int'(m_cnt[i]) == m_max[i]) : (m_cnt[i] == 4'd0);
  endfunction

  // Drive one edge: check AtLimit before the edge, push the expected
  // post-edge state, then pop and compare once the DUT has updated.
  task automatic cycle(input bit rst, input bit ld, input logic [3:0] lv,
                       input bit en, input bit ud);
    exp_t       e;
    logic [3:0] nc [3];
    logic       nt [3];
    Rst = rst; Load = ld; LoadVal = lv; Enable = en; UpDown = ud;
    #1;
    if (m_known) begin
      check_eq("atlim_wrap", al_w, exp_atlim(0, ud));
      check_eq("atlim_sat",  al_s, exp_atlim(1, ud));
      check_eq("atlim_def",  al_d, exp_atlim(2, ud));
    end
    for (int i = 0; i < 3; i++) begin
      model_step(m_cnt[i], m_max[i], m_sat[i], rst, ld, lv, en, ud, nc[i], nt[i]);
    end
    e = '{cw: nc[0], tw: nt[0], cs: nc[1], ts: nt[1], cd: nc[2], td: nt[2]};
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (m_known || rst) begin
        check_eq("cnt_wrap", cnt_w, e.cw);
        check_eq("tc_wrap",  tc_w,  e.tw);
        check_eq("cnt_sat",  cnt_s, e.cs);
        check_eq("tc_sat",   tc_s,  e.ts);
        check_eq("cnt_def",  cnt_d, e.cd);
        check_eq("tc_def",   tc_d,  e.td);
      end
    end
    for (int i = 0; i < 3; i++) m_cnt[i] = nc[i];
    if (rst) m_known = 1'b1;
  endtask

  int seq032 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int seq034 [5]  = '{8, 9, 9, 9, 9};

  initial begin
    Rst = 1'b1; Load = 1'b0; LoadVal = 4'd0; Enable = 1'b0; UpDown = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 4'd0;

    // Reset state
    cycle(1, 0, 4'd0, 0, 0);
    cycle(1, 0, 4'd0, 0, 1);
    check_eq("rst_cnt", cnt_w, 0);
    check_eq("rst_tc", tc_w, 0);
    check_eq("rst_atlim_up", al_w, 0);

    // Wrap up through MAX
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 4'd0, 1, 1);
      check_eq("wrap_up_cnt", cnt_w, seq032[i]);
      check_eq("wrap_up_tc", tc_w, (i == 9) ? 1 : 0);
    end

    // Wrap down from 0
    cycle(1, 0, 4'd0, 0, 0);
    cycle(0, 0, 4'd0, 1, 0);
    check_eq("wrap_dn_cnt0", cnt_w, 9);
    check_eq("wrap_dn_tc0", tc_w, 1);
    cycle(0, 0, 4'd0, 1, 0);
    check_eq("wrap_dn_cnt1", cnt_w, 8);
    check_eq("wrap_dn_tc1", tc_w, 0);

    // Saturate at MAX
    cycle(0, 1, 4'd7, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 4'd0, 1, 1);
      check_eq("sat_up_cnt", cnt_s, seq034[i]);
      check_eq("sat_up_tc", tc_s, (i >= 2) ? 1 : 0);
      check_eq("sat_up_atlim", al_s, (i >= 1) ? 1 : 0);
    end

    // Load above MAX clamps, beats Enable
    cycle(0, 1, 4'd13, 1, 1);
    check_eq("load_clamp_cnt", cnt_w, 9);
    check_eq("load_clamp_tc", tc_w, 0);
    check_eq("load_noclamp_def", cnt_d, 13);
    cycle(0, 1, 4'd4, 0, 1);
    check_eq("load4_cnt", cnt_w, 4);

    // Reset overrides Load mid-count
    cycle(0, 0, 4'd0, 1, 1);
    cycle(0, 0, 4'd0, 1, 1);
    check_eq("pre_rst_cnt", cnt_w, 6);
    cycle(1, 1, 4'd3, 1, 1);
    check_eq("rst_load_cnt", cnt_w, 0);
    check_eq("rst_load_tc", tc_w, 0);
    cycle(0, 0, 4'd0, 1, 1);
    check_eq("post_rst_cnt", cnt_w, 1);

    // Hold with UpDown toggling
    cycle(0, 1, 4'd5, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 4'd0, 0, i[0]);
      check_eq("hold_cnt", cnt_w, 5);
      check_eq("hold_tc", tc_w, 0);
      check_eq("hold_atlim", al_w, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
      check_eq("wrap_le_max", (cnt_w <= 4'd9) ? 1 : 0, 1);
      check_eq("sat_le_max", (cnt_s <= 4'd9) ? 1 : 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MAX, default 2**WIDTH-1: upper count limit, legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Clk  input  1  rising-edge clock.
REQ-006 Rst  input  1  synchronous active-high reset.
REQ-007 Enable  input  1  count step enable.
REQ-008 UpDown  input  1  1 = count up, 0 = count down.
REQ-009 Load  input  1  synchronous parallel load strobe.
REQ-010 LoadVal  input  WIDTH  value to load.
REQ-011 Count  output  WIDTH  registered count value.
REQ-012 Tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 AtLimit  output  1  combinational: Count equals MAX when UpDown=1, or 0 when UpDown=0.

Function
REQ-014 Priority per rising edge SHALL be: Rst, then Load, then Enable, then hold.
REQ-015 Load=1 SHALL set Count to LoadVal next cycle, or to MAX if LoadVal>MAX; Tc=0 that cycle.
REQ-016 Enable=1, UpDown=1, Count<MAX SHALL give Count+1 next cycle.
REQ-017 Enable=1, UpDown=0, Count>0 SHALL give Count-1 next cycle.
REQ-018 Enable=1, UpDown=1, Count==MAX SHALL give 0 if SATURATE=0, or hold MAX if SATURATE=1.
REQ-019 Enable=1, UpDown=0, Count==0 SHALL give MAX if SATURATE=0, or hold 0 if SATURATE=1.
REQ-020 Tc SHALL be 1 for exactly the cycle after a REQ-018/REQ-019 event, and 0 otherwise.
REQ-021 In SATURATE=1 mode, Tc SHALL pulse on each enabled cycle spent at the limit.
REQ-022 Enable=0 with Load=0 SHALL hold Count and drive Tc=0.
REQ-023 A change of UpDown SHALL take effect on the same edge it is sampled, with no dead cycle.
REQ-024 Count SHALL never exceed MAX under any input sequence.
REQ-025 Latency from sampled input to Count/Tc update SHALL be one clock.

Reset
REQ-026 Rst=1 at a rising edge SHALL set Count=0 and Tc=0, overriding Load and Enable.
REQ-027 Asserting Rst mid-count SHALL discard the in-progress step; counting resumes from 0 on the first edge after Rst=0.
REQ-028 AtLimit during reset SHALL follow REQ-013 from the reset Count value.

Structure
REQ-029 Mode encodings (MODE_WRAP=0, MODE_SAT=1) and the WIDTH range limits SHALL live in the shared counter constants package/header.
REQ-030 Next-value and limit-compare logic SHALL be one combinational sub-module, count_next; param_counter holds only the registers.
REQ-031 All state SHALL be in a single clocked always block; there SHALL be no latches and no derived clocks.

Verification
REQ-032 WIDTH=4, MAX=9, SATURATE=0: Rst, then Enable=1, UpDown=1 for 12 cycles -> Count 1..9,0,1,2; Tc=1 only in the cycle Count becomes 0.
REQ-033 Same configuration, Count=0, UpDown=0, Enable=1 -> Count 9 next cycle, Tc=1; then 8, Tc=0.
REQ-034 SATURATE=1, MAX=9: count up from 7 for 5 cycles -> 8,9,9,9,9; Tc=1 in each of the last three cycles; AtLimit=1 while Count=9.
REQ-035 Load=1 with LoadVal=13, MAX=9, Enable=1 in the same cycle -> Count=9, Tc=0; a later Load with LoadVal=4 -> Count=4.
REQ-036 Count up to 6, assert Rst together with Load=1 and LoadVal=3 -> Count=0, Tc=0; release Rst with Enable=1 -> Count 1.
REQ-037 Enable=0 for 10 cycles at Count=5 with UpDown toggling -> Count stays 5, Tc stays 0, AtLimit stays 0.
